// File: rtl/cr_ifu_ifex_buf.sv
// cr_ifu_ifex_buf: two-entry instruction buffer between the IF data path and
// the IU EX stage. Each fetched instruction is stored with its PC, breakpoint
// flag and compressed-instruction flag. A debug breakpoint replaces the
// instruction with EBREAK. One cycle of EX back-pressure is absorbed without
// losing fetch data, and an IU kill flushes the buffer.
module cr_ifu_ifex_buf #(
  parameter logic [31:0] EBREAK = 32'h00100073
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        if_inst_vld,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  input  logic        ifu_iu_ex_inst_bkpt,
  input  logic        iu_ifu_kill_inst,
  input  logic        iu_ifu_ex_stall,
  output logic        ifu_if_ready,
  output logic        ifu_iu_ex_inst_vld,
  output logic [31:0] ifu_iu_ex_inst,
  output logic [31:0] ifu_iu_ex_pc,
  output logic        ifu_iu_ex_bkpt,
  output logic        ifu_iu_ex_inst_16
);

  // Entry storage, indexed by the 1-bit pointers.
  logic [31:0] inst_q [2];
  logic [31:0] pc_q   [2];
  logic        bkpt_q [2];
  logic        c16_q  [2];

  // Pointers and occupancy.
  logic        wptr_q;
  logic        wptr_d;
  logic        rptr_q;
  logic        rptr_d;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;

  // Handshake and write-data signals.
  logic        push_s;
  logic        pop_s;
  logic [31:0] wr_inst_s;
  logic        wr_bkpt_s;
  logic        wr_c16_s;

  // Ready depends only on the registered count and kill; push/pop qualifiers.
  always_comb begin
    ifu_if_ready = 1'b0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    if (!iu_ifu_kill_inst && (cnt_q != 2'd2)) begin
      ifu_if_ready = 1'b1;
    end else begin
      ifu_if_ready = 1'b0;
    end
    push_s = if_inst_vld & ifu_if_ready;
    pop_s  = (cnt_q != 2'd0) & ~iu_ifu_ex_stall;
  end

  // Entry contents to load on a push; a breakpoint replaces the instruction.
  always_comb begin
    wr_inst_s = if_inst;
    wr_bkpt_s = 1'b0;
    wr_c16_s  = 1'b0;
    if (ifu_iu_ex_inst_bkpt) begin
      wr_inst_s = EBREAK;
      wr_bkpt_s = 1'b1;
      wr_c16_s  = 1'b0;
    end else begin
      wr_inst_s = if_inst;
      wr_bkpt_s = 1'b0;
      wr_c16_s  = (if_inst[1:0] != 2'b11);
    end
  end

  // Next pointer/count; a kill discards any push or pop in the same cycle.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (iu_ifu_kill_inst) begin
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (push_s) begin
        wptr_d = ~wptr_q;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = ~rptr_q;
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry registers; only the slot at the write pointer loads on a push.
  // push_s is already low during a kill because ready is forced low.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      for (int i = 0; i < 2; i++) begin
        inst_q[i] <= 32'h0000_0000;
        pc_q[i]   <= 32'h0000_0000;
        bkpt_q[i] <= 1'b0;
        c16_q[i]  <= 1'b0;
      end
    end else if (push_s) begin
      inst_q[wptr_q] <= wr_inst_s;
      pc_q[wptr_q]   <= if_pc;
      bkpt_q[wptr_q] <= wr_bkpt_s;
      c16_q[wptr_q]  <= wr_c16_s;
    end
  end

  // Head outputs come straight from the entry at the read pointer.
  always_comb begin
    ifu_iu_ex_inst_vld = (cnt_q != 2'd0);
    ifu_iu_ex_inst     = inst_q[rptr_q];
    ifu_iu_ex_pc       = pc_q[rptr_q];
    ifu_iu_ex_bkpt     = bkpt_q[rptr_q];
    ifu_iu_ex_inst_16  = c16_q[rptr_q];
  end

endmodule

// File: tb/tb_cr_ifu_ifex_buf.sv
// Self-checking bench for cr_ifu_ifex_buf: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_cr_ifu_ifex_buf;

  localparam logic [31:0] EBREAK_C = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_inst_vld;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        bkpt_in;
  logic        kill;
  logic        stall;
  logic        ready;
  logic        ex_vld;
  logic [31:0] ex_inst;
  logic [31:0] ex_pc;
  logic        ex_bkpt;
  logic        ex_c16;

  cr_ifu_ifex_buf #(.EBREAK(EBREAK_C)) dut (
    .forever_cpuclk      (clk),
    .cpurst              (rst),
    .if_inst_vld         (if_inst_vld),
    .if_inst             (if_inst),
    .if_pc               (if_pc),
    .ifu_iu_ex_inst_bkpt (bkpt_in),
    .iu_ifu_kill_inst    (kill),
    .iu_ifu_ex_stall     (stall),
    .ifu_if_ready        (ready),
    .ifu_iu_ex_inst_vld  (ex_vld),
    .ifu_iu_ex_inst      (ex_inst),
    .ifu_iu_ex_pc        (ex_pc),
    .ifu_iu_ex_bkpt      (ex_bkpt),
    .ifu_iu_ex_inst_16   (ex_c16)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        bkpt;
    logic        c16;
  } ent_t;

  ent_t mq[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare head outputs against the model's oldest entry.
  task automatic check_head(input string tag);
    chk({tag, ".vld"}, {31'd0, ex_vld}, {31'd0, (mq.size() != 0)});
    if (mq.size() != 0) begin
      chk({tag, ".inst"}, ex_inst, mq[0].inst);
      chk({tag, ".pc"}, ex_pc, mq[0].pc);
      chk({tag, ".bkpt"}, {31'd0, ex_bkpt}, {31'd0, mq[0].bkpt});
      chk({tag, ".c16"}, {31'd0, ex_c16}, {31'd0, mq[0].c16});
    end
  endtask

  // One clock cycle: drive at negedge, check ready, advance model, check head.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic bk, input logic kl, input logic st);
    ent_t e;
    bit   push;
    bit   pop;
    if_inst_vld = v;
    if_inst     = ins;
    if_pc       = pc;
    bkpt_in     = bk;
    kill        = kl;
    stall       = st;
    #1;
    push = v && (mq.size() < 2) && !kl;
    pop  = (mq.size() != 0) && !st;
    chk("ready", {31'd0, ready}, {31'd0, ((mq.size() < 2) && !kl)});
    e.inst = bk ? EBREAK_C : ins;
    e.pc   = pc;
    e.bkpt = bk;
    e.c16  = !bk && (ins[1:0] != 2'b11);
    @(posedge clk);
    if (kl) begin
      mq.delete();
    end else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    @(negedge clk);
    check_head("step");
  endtask

  initial begin
    rst         = 1'b1;
    if_inst_vld = 1'b0;
    if_inst     = 32'h0;
    if_pc       = 32'h0;
    bkpt_in     = 1'b0;
    kill        = 1'b0;
    stall       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.vld", {31'd0, ex_vld}, 32'd0);
    chk("rst.inst", ex_inst, 32'h0);
    chk("rst.pc", ex_pc, 32'h0);
    chk("rst.bkpt", {31'd0, ex_bkpt}, 32'd0);
    chk("rst.c16", {31'd0, ex_c16}, 32'd0);
    chk("rst.ready", {31'd0, ready}, 32'd1);
    @(negedge clk);

    // Single 32-bit instruction, one cycle latency, then drains.
    step(1'b1, 32'h00a50533, 32'h100, 1'b0, 1'b0, 1'b0);
    chk("t1.inst", ex_inst, 32'h00a50533);
    chk("t1.pc", ex_pc, 32'h100);
    chk("t1.c16", {31'd0, ex_c16}, 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t1.empty", {31'd0, ex_vld}, 32'd0);

    // Breakpoint substitution, then the same compressed instruction without it.
    step(1'b1, 32'h00004505, 32'h200, 1'b1, 1'b0, 1'b0);
    chk("t2.ebreak", ex_inst, 32'h00100073);
    chk("t2.bkpt", {31'd0, ex_bkpt}, 32'd1);
    chk("t2.c16bk", {31'd0, ex_c16}, 32'd0);
    step(1'b1, 32'h00004505, 32'h204, 1'b0, 1'b0, 1'b0);
    chk("t2.c16", {31'd0, ex_c16}, 32'd1);
    chk("t2.inst", ex_inst, 32'h00004505);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Back-pressure: A, B accepted, C held; then drained in order.
    step(1'b1, 32'h11111113, 32'h300, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h22222223, 32'h304, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h33333333, 32'h308, 1'b0, 1'b0, 1'b1);
    chk("t3.headA", ex_inst, 32'h11111113);
    step(1'b1, 32'h33333333, 32'h308, 1'b0, 1'b0, 1'b0);
    chk("t3.headB", ex_inst, 32'h22222223);
    step(1'b1, 32'h33333333, 32'h308, 1'b0, 1'b0, 1'b0);
    chk("t3.headC", ex_inst, 32'h33333333);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t3.empty", {31'd0, ex_vld}, 32'd0);

    // Kill with two entries held and a new instruction offered.
    step(1'b1, 32'h44444443, 32'h400, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h55555553, 32'h404, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h66666663, 32'h408, 1'b0, 1'b1, 1'b1);
    chk("t5.killvld", {31'd0, ex_vld}, 32'd0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t5.nostore", {31'd0, ex_vld}, 32'd0);

    // Asynchronous reset while full.
    step(1'b1, 32'h77777773, 32'h500, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h88888883, 32'h504, 1'b0, 1'b0, 1'b1);
    if_inst_vld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar.vld", {31'd0, ex_vld}, 32'd0);
    chk("ar.inst", ex_inst, 32'h0);
    chk("ar.pc", ex_pc, 32'h0);
    chk("ar.ready", {31'd0, ready}, 32'd1);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'h99999993, 32'h600, 1'b0, 1'b0, 1'b1);
    chk("ar.first", ex_inst, 32'h99999993);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7),
           $urandom(),
           {$urandom_range(0, 32'h7fff_ffff), 1'b0},
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cr_ifu_ifex_buf.md
# cr_ifu_ifex_buf

Two-entry instruction buffer between the IF data path and the IU EX stage. It registers each fetched instruction with its PC and breakpoint flag, and substitutes EBREAK when the IF stage flags a debug breakpoint. It absorbs one cycle of EX back-pressure without dropping fetch data and flushes on an IU kill. It is the consumer of the IF-stage `ifu_iu_ex_inst_bkpt` indication and the producer of EX-stage instruction valid/data.

## Interface
- `EBREAK`, default 32'h00100073: encoding substituted for a breakpointed instruction.
- `forever_cpuclk`  in  1  the block's only clock. All state updates on the rising edge.
- `cpurst`  in  1  asynchronous, active-high reset.
- `if_inst_vld`  in  1  IF presents an instruction this cycle.
- `if_inst`  in  32  fetched instruction; bits [1:0] != 2'b11 means a 16-bit compressed instruction in [15:0].
- `if_pc`  in  32  PC of `if_inst`; bit 0 is always 0.
- `ifu_iu_ex_inst_bkpt`  in  1  breakpoint request for the current IF instruction.
- `iu_ifu_kill_inst`  in  1  flush request from IU; takes priority over everything else.
- `iu_ifu_ex_stall`  in  1  EX cannot consume the head entry this cycle.
- `ifu_if_ready`  out  1  buffer can accept; high when occupancy < 2 and `iu_ifu_kill_inst`=0.
- `ifu_iu_ex_inst_vld`  out  1  head entry is valid.
- `ifu_iu_ex_inst`  out  32  head instruction (EBREAK if breakpointed).
- `ifu_iu_ex_pc`  out  32  head PC.
- `ifu_iu_ex_bkpt`  out  1  head entry was replaced by the breakpoint.
- `ifu_iu_ex_inst_16`  out  1  head is compressed; forced 0 for a breakpointed entry.

## Operation
- Storage: 2 entries {inst, pc, bkpt, c16}, a 1-bit write pointer, a 1-bit read pointer, and a 2-bit occupancy count (0..2).
- Push = `if_inst_vld` & `ifu_if_ready`. Pop = `ifu_iu_ex_inst_vld` & !`iu_ifu_ex_stall`.
- On push, the entry at the write pointer is loaded:
  - If `ifu_iu_ex_inst_bkpt`=1: inst=EBREAK, bkpt=1, c16=0.
  - Otherwise: inst=`if_inst`, bkpt=0, c16=(`if_inst`[1:0]!=2'b11).
  - pc=`if_pc` in both cases. The write pointer toggles.
- On pop, the read pointer toggles.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Outputs are driven directly from the entry at the read pointer. `ifu_iu_ex_inst_vld` = (count != 0).
- Kill: on the next edge, count=0 and both pointers=0. A push or pop in the kill cycle is discarded. Entry data is not cleared.
- Full (count=2): ready=0, so IF must hold. A pop in the full cycle frees a slot, but ready reflects the registered count and stays 0 for that cycle. There is no combinational path from `iu_ifu_ex_stall` to ready.
- Empty (count=0): a pop cannot occur because valid=0. There is no bypass: data written this cycle is visible next cycle.
- Pointers wrap modulo 2.

## Timing
- Reset values: count=0, pointers=0, all entries 0. Therefore `ifu_iu_ex_inst_vld`=0, `ifu_iu_ex_inst`=0, `ifu_iu_ex_pc`=0, `ifu_iu_ex_bkpt`=0, `ifu_iu_ex_inst_16`=0, and `ifu_if_ready`=1 (when kill=0).
- Latency from push to the head output is 1 cycle when empty, or one cycle after the preceding entry pops.
- Sustained throughput is 1 instruction per cycle with no stall.
- Reset asserted mid-operation clears all state asynchronously. Outputs take their reset values without waiting for a clock edge.
- `ifu_if_ready` is combinational from count and kill only.

## Test plan
- Reset, then push `if_inst`=32'h00a50533 with pc=32'h100 and stall=0:
  - Next cycle: vld=1, inst=32'h00a50533, pc=32'h100, bkpt=0, inst_16=0.
  - One cycle later: vld=0.
- Push 16-bit `if_inst`=32'h0000_4505 with bkpt=1: head shows inst=32'h00100073, bkpt=1, inst_16=0. Repeat with bkpt=0: inst_16=1.
- Stall=1 and push A, B, C on consecutive cycles:
  - Ready drops after B, so C is held by IF.
  - Release stall: A, B, C emerge in order, one per cycle, with no loss or duplication.
- Buffer full with A, B; pop and push in the same cycle: ready=0 in that cycle, so no push occurs. Next cycle count=1 with B at the head and ready=1.
- Two entries held, assert kill together with `if_inst_vld`: next cycle vld=0, count=0, and the killed-cycle instruction is not stored.
- Assert `cpurst` asynchronously while count=2: outputs zero immediately. After release, the first push appears at the head after 1 cycle.
